// File: rtl/shiftin_multi.sv
// -----------------------------------------------------------------------------
// shiftin_multi
//
// Multi-channel console controller shift register. CHANNELS independent
// BITS-wide button words are parallel-loaded while the console holds latch
// high, then shifted out MSB first, one bit per console clk rising edge. After
// BITS shifts every output rests at FILL_BIT until the next latch.
//
// The console pins (clk, latch) are asynchronous to system_clock. Each passes
// through a synchroniser and a history flop, and only the detected levels and
// edges drive the state machine. The pin-to-data latency is 3 cycles
// (2 sync + 1 update).
//
// Optional feature, macro SHIFTIN_MULTI_FILTER_EN:
//   adds a third sync stage per pin. A pin's filtered level changes only when
//   the two newest synchronised samples agree, so a single-cycle glitch is
//   rejected. The pin-to-data latency becomes 4 cycles.
//
// Ports:
//   system_clock  in   1               sole clock, rising edge
//   reset         in   1               synchronous, active-high
//   clk           in   1               console shift clock (asynchronous)
//   latch         in   1               console latch (asynchronous, active-high)
//   i             in   CHANNELS*BITS   parallel words, channel n at i[n*BITS +: BITS]
//   data          out  CHANNELS        serial outputs, data[n] for channel n
//   busy          out  1               high while shifting
//   poll          out  1               one-cycle pulse on latch falling edge
// -----------------------------------------------------------------------------
module shiftin_multi #(
  parameter int   BITS     = 16,
  parameter int   CHANNELS = 1,
  parameter logic FILL_BIT = 1'b1
) (
  input  logic                       system_clock,
  input  logic                       reset,
  input  logic                       clk,
  input  logic                       latch,
  input  logic [CHANNELS*BITS-1:0]   i,
  output logic [CHANNELS-1:0]        data,
  output logic                       busy,
  output logic                       poll
);

`ifdef SHIFTIN_MULTI_FILTER_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 2;
`endif

  localparam int CW = $clog2(BITS + 1);
  localparam int SRW = CHANNELS * BITS;
  localparam logic [CW-1:0] LAST_CNT = CW'(BITS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BITS);
  localparam logic [SRW-1:0] FILL_ALL = {SRW{FILL_BIT}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic [STAGES-1:0] clk_sync_q;
  logic [STAGES-1:0] latch_sync_q;
  logic              clk_h_q;
  logic              latch_h_q;
  logic              clk_s;
  logic              latch_s;
  logic              clk_rise_s;
  logic              latch_fall_s;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SRW-1:0]    sr_q, sr_d;
  logic              busy_q, busy_d;
  logic              poll_q, poll_d;

  // Pin synchronisers plus one history flop per pin for edge detection.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      clk_sync_q   <= '0;
      latch_sync_q <= '0;
      clk_h_q      <= 1'b0;
      latch_h_q    <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[STAGES-2:0], clk};
      latch_sync_q <= {latch_sync_q[STAGES-2:0], latch};
      clk_h_q      <= clk_s;
      latch_h_q    <= latch_s;
    end
  end

  // Effective pin levels. With filtering, a level only moves once the two
  // newest samples agree; otherwise the previous level (history flop) holds.
  always_comb begin
    clk_s   = clk_sync_q[1];
    latch_s = latch_sync_q[1];
`ifdef SHIFTIN_MULTI_FILTER_EN
    if (clk_sync_q[2] == clk_sync_q[1]) begin
      clk_s = clk_sync_q[1];
    end else begin
      clk_s = clk_h_q;
    end
    if (latch_sync_q[2] == latch_sync_q[1]) begin
      latch_s = latch_sync_q[1];
    end else begin
      latch_s = latch_h_q;
    end
`endif
    clk_rise_s   = clk_s & ~clk_h_q;
    latch_fall_s = ~latch_s & latch_h_q;
  end

  // Next-state logic. A high latch level takes priority over everything:
  // it reloads the words, clears the counter and aborts any shift, which also
  // makes latch win over a simultaneous clk edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    poll_d  = 1'b0;
    if (latch_s) begin
      state_d = LOAD;
      cnt_d   = '0;
      sr_d    = i;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        LOAD: begin
          // clk edges are ignored here, including one coinciding with release
          if (latch_fall_s) begin
            state_d = SHIFT;
            cnt_d   = '0;
            poll_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
        SHIFT: begin
          if (clk_rise_s) begin
            for (int n = 0; n < CHANNELS; n++) begin
              sr_d[n*BITS +: BITS] = {sr_q[n*BITS +: BITS-1], FILL_BIT};
            end
            if (cnt_q == LAST_CNT) begin
              state_d = DONE;
              cnt_d   = FULL_CNT;
              sr_d    = FILL_ALL;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = SHIFT;
          end
        end
        DONE: begin
          // counter saturated at BITS, outputs rest at FILL_BIT
          state_d = DONE;
          cnt_d   = FULL_CNT;
          sr_d    = FILL_ALL;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sr_d    = FILL_ALL;
        end
      endcase
    end
    busy_d = (state_d == SHIFT);
  end

  // State, counter, shift registers and registered status outputs.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '1;
      busy_q  <= 1'b0;
      poll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
      poll_q  <= poll_d;
    end
  end

  // Each data line is the MSB flop of its channel's shift register.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_data
    assign data[g] = sr_q[g*BITS + BITS - 1];
  end

  assign busy = busy_q;
  assign poll = poll_q;

endmodule

// File: tb/tb_shiftin_multi.sv
// -----------------------------------------------------------------------------
// tb_shiftin_multi
//
// Bench for shiftin_multi with BITS=16, CHANNELS=2. Drives the console pins
// on the falling edge of system_clock and samples outputs there as well.
// Expected serial bits come from the captured words: bit k of a frame on
// channel n is word_n[BITS-1-k] for k < BITS and FILL otherwise.
// -----------------------------------------------------------------------------
module tb_shiftin_multi;

  localparam int   BITS = 16;
  localparam int   CH   = 2;
  localparam int   W    = BITS * CH;
  localparam logic FILL = 1'b1;
`ifdef SHIFTIN_MULTI_FILTER_EN
  localparam int   LAT  = 4;
`else
  localparam int   LAT  = 3;
`endif

  logic          system_clock = 1'b0;
  logic          reset;
  logic          clk;
  logic          latch;
  logic [W-1:0]  i;
  logic [CH-1:0] data;
  logic          busy;
  logic          poll;

  int checks_total  = 0;
  int checks_passed = 0;
  int poll_cnt      = 0;

  shiftin_multi #(
    .BITS     (BITS),
    .CHANNELS (CH),
    .FILL_BIT (FILL)
  ) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .clk          (clk),
    .latch        (latch),
    .i            (i),
    .data         (data),
    .busy         (busy),
    .poll         (poll)
  );

  always #5 system_clock = ~system_clock;

  // Count poll pulses seen on rising edges.
  always @(posedge system_clock) begin
    if (poll === 1'b1) poll_cnt <= poll_cnt + 1;
  end

  // Reference: the bit the console reads after k shifts of a frame of word w.
  function automatic logic [CH-1:0] exp_bits(input logic [W-1:0] w, input int k);
    logic [CH-1:0] r;
    for (int n = 0; n < CH; n++) begin
      if (k < BITS) r[n] = w[n*BITS + BITS - 1 - k];
      else          r[n] = FILL;
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge system_clock);
  endtask

  // Hold latch, check load behaviour, release and check poll/busy.
  task automatic do_latch(input logic [W-1:0] w);
    int p0;
    i = w;
    latch = 1'b1;
    tick(10);
    checks_total++;
    if (busy !== 1'b0) $display("FAIL load_busy: busy=%b expected=0", busy);
    else checks_passed++;
    checks_total++;
    if (data !== exp_bits(w, 0)) $display("FAIL load_msb: data=%b expected=%b", data, exp_bits(w, 0));
    else checks_passed++;
    p0 = poll_cnt;
    latch = 1'b0;
    tick(8);
    checks_total++;
    if (poll_cnt - p0 !== 1) $display("FAIL poll_once: pulses=%0d expected=1", poll_cnt - p0);
    else checks_passed++;
    checks_total++;
    if (busy !== 1'b1) $display("FAIL shift_busy: busy=%b expected=1", busy);
    else checks_passed++;
  endtask

  // Read n bits starting at position k0, pulsing clk after each read.
  task automatic do_reads(input logic [W-1:0] w, input int k0, input int n, input bit scramble);
    for (int k = k0; k < k0 + n; k++) begin
      checks_total++;
      if (data !== exp_bits(w, k)) $display("FAIL bit k=%0d: data=%b expected=%b", k, data, exp_bits(w, k));
      else checks_passed++;
      clk = 1'b1;
      tick(4);
      if (scramble) i = {$urandom, $urandom};
      clk = 1'b0;
      tick(4);
    end
  endtask

  task automatic check_after(input logic [W-1:0] w, input int k);
    checks_total++;
    if (data !== exp_bits(w, k)) $display("FAIL after k=%0d: data=%b expected=%b", k, data, exp_bits(w, k));
    else checks_passed++;
    checks_total++;
    if (busy !== (k < BITS)) $display("FAIL busy_after k=%0d: busy=%b expected=%b", k, busy, (k < BITS));
    else checks_passed++;
  endtask

  task automatic test_reset;
    reset = 1'b1; clk = 1'b0; latch = 1'b0; i = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    checks_total++;
    if (data !== 2'b11) $display("FAIL reset_data: data=%b expected=11", data);
    else checks_passed++;
    checks_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b expected=0", busy);
    else checks_passed++;
    checks_total++;
    if (poll !== 1'b0) $display("FAIL reset_poll: poll=%b expected=0", poll);
    else checks_passed++;
  endtask

  task automatic test_directed;
    logic [W-1:0] w;
    w = {16'h8001, 16'h0000};
    do_latch(w);
    do_reads(w, 0, 16, 1'b0);
    check_after(w, 16);
  endtask

  task automatic test_overrun;
    logic [W-1:0] w;
    w = {$urandom, $urandom};
    do_latch(w);
    do_reads(w, 0, 20, 1'b1);
    check_after(w, 20);
  endtask

  task automatic test_abort;
    logic [W-1:0] w;
    logic [W-1:0] w2;
    w  = {$urandom, $urandom};
    w2 = {16'hA5A5, 16'hA5A5};
    do_latch(w);
    do_reads(w, 0, 5, 1'b0);
    do_latch(w2);
    do_reads(w2, 0, 16, 1'b1);
    check_after(w2, 16);
  endtask

  // clk rising with latch rising, then clk rising with latch falling.
  task automatic test_same_cycle;
    logic [W-1:0] wa;
    logic [W-1:0] wb;
    logic [CH-1:0] old_v;
    wa = {$urandom, $urandom};
    do_latch(wa);
    do_reads(wa, 0, 3, 1'b0);
    old_v = exp_bits(wa, 3);
    wb = {$urandom, $urandom};
    wb[BITS-1]   = ~old_v[0];
    wb[2*BITS-1] = ~old_v[1];
    i = wb;
    latch = 1'b1;
    clk = 1'b1;
    tick(LAT - 1);
    checks_total++;
    if (data !== old_v) $display("FAIL same_pre: data=%b expected=%b", data, old_v);
    else checks_passed++;
    tick(1);
    checks_total++;
    if (data !== exp_bits(wb, 0)) $display("FAIL same_load: data=%b expected=%b", data, exp_bits(wb, 0));
    else checks_passed++;
    clk = 1'b0;
    tick(6);
    latch = 1'b0;
    clk = 1'b1;
    tick(8);
    checks_total++;
    if (data !== exp_bits(wb, 0)) $display("FAIL fall_noshift: data=%b expected=%b", data, exp_bits(wb, 0));
    else checks_passed++;
    checks_total++;
    if (busy !== 1'b1) $display("FAIL fall_busy: busy=%b expected=1", busy);
    else checks_passed++;
    clk = 1'b0;
    tick(4);
    do_reads(wb, 0, 16, 1'b1);
    check_after(wb, 16);
  endtask

  // Exact clk-to-data latency, plus glitch rejection when filtering.
  task automatic test_latency;
    logic [W-1:0] w;
    w = {$urandom, $urandom};
    do_latch(w);
    do_reads(w, 0, 2, 1'b0);
    clk = 1'b1;
    tick(LAT - 1);
    checks_total++;
    if (data !== exp_bits(w, 2)) $display("FAIL lat_pre: data=%b expected=%b", data, exp_bits(w, 2));
    else checks_passed++;
    tick(1);
    checks_total++;
    if (data !== exp_bits(w, 3)) $display("FAIL lat_post: data=%b expected=%b", data, exp_bits(w, 3));
    else checks_passed++;
    clk = 1'b0;
    tick(4);
`ifdef SHIFTIN_MULTI_FILTER_EN
    clk = 1'b1;
    tick(1);
    clk = 1'b0;
    tick(8);
    checks_total++;
    if (data !== exp_bits(w, 3)) $display("FAIL glitch: data=%b expected=%b", data, exp_bits(w, 3));
    else checks_passed++;
    clk = 1'b1;
    tick(3);
    checks_total++;
    if (data !== exp_bits(w, 3)) $display("FAIL pulse3_pre: data=%b expected=%b", data, exp_bits(w, 3));
    else checks_passed++;
    clk = 1'b0;
    tick(1);
    checks_total++;
    if (data !== exp_bits(w, 4)) $display("FAIL pulse3_post: data=%b expected=%b", data, exp_bits(w, 4));
    else checks_passed++;
    tick(4);
    do_reads(w, 4, 12, 1'b0);
`else
    do_reads(w, 3, 13, 1'b0);
`endif
    check_after(w, 16);
  endtask

  task automatic test_random_frames;
    logic [W-1:0] w;
    int n;
    for (int f = 0; f < 4; f++) begin
      w = {$urandom, $urandom};
      n = $urandom_range(1, 20);
      do_latch(w);
      do_reads(w, 0, n, 1'b1);
      check_after(w, n);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] w;
    w = {$urandom, $urandom};
    w[2*BITS-2] = 1'b0;
    do_latch(w);
    do_reads(w, 0, 4, 1'b0);
    reset = 1'b1;
    tick(1);
    checks_total++;
    if (data !== 2'b11) $display("FAIL rst_mid_data: data=%b expected=11", data);
    else checks_passed++;
    checks_total++;
    if (busy !== 1'b0) $display("FAIL rst_mid_busy: busy=%b expected=0", busy);
    else checks_passed++;
    reset = 1'b0;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      clk = 1'b1;
      tick(4);
      clk = 1'b0;
      tick(4);
    end
    checks_total++;
    if (data !== 2'b11) $display("FAIL rst_noshift_data: data=%b expected=11", data);
    else checks_passed++;
    checks_total++;
    if (busy !== 1'b0) $display("FAIL rst_noshift_busy: busy=%b expected=0", busy);
    else checks_passed++;
    w = {$urandom, $urandom};
    do_latch(w);
    do_reads(w, 0, 16, 1'b0);
    check_after(w, 16);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_overrun;
    test_abort;
    test_same_cycle;
    test_latency;
    test_random_frames;
    test_reset_mid;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
